// File: rtl/m_to_n_fifo.sv
// Single-clock FIFO with M write lanes and N read lanes per cycle.
// Lanes are served lowest index first, so a cycle's lane order becomes FIFO order.
module m_to_n_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 5,
    parameter int PFULL_TH  = 8,
    parameter int PEMPTY_TH = 8,
    parameter int M_WRITERS = 2,
    parameter int N_READERS = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic [M_WRITERS-1:0]         i_wr_en,
    input  logic [M_WRITERS*WIDTH-1:0]   i_wr_data,
    output logic [M_WRITERS-1:0]         o_wr_ed,
    output logic                         o_wr_full,
    output logic                         o_wr_afull,
    output logic                         o_wr_pfull,
    output logic [DEPTH:0]               o_wr_remain,
    input  logic [N_READERS-1:0]         i_rd_en,
    output logic [N_READERS*WIDTH-1:0]   o_rd_data,
    output logic [N_READERS-1:0]         o_rd_valid,
    output logic                         o_rd_empty,
    output logic                         o_rd_aempty,
    output logic                         o_rd_pempty,
    output logic [DEPTH:0]               o_rd_depth
);

    localparam int CNT_W   = DEPTH + 1;
    localparam int ENTRIES = 2 ** DEPTH;

    localparam logic [CNT_W-1:0] ENTRIES_C   = CNT_W'(ENTRIES);
    localparam logic [CNT_W-1:0] M_C         = CNT_W'(M_WRITERS);
    localparam logic [CNT_W-1:0] N_C         = CNT_W'(N_READERS);
    localparam logic [CNT_W-1:0] PFULL_C     = CNT_W'(PFULL_TH);
    localparam logic [CNT_W-1:0] PEMPTY_C    = CNT_W'(PEMPTY_TH);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    logic [WIDTH-1:0] mem [ENTRIES];

    logic [DEPTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] free_entries;

    logic [M_WRITERS-1:0] wr_grant;
    logic [N_READERS-1:0] rd_grant;
    logic [CNT_W-1:0]     wr_rank [M_WRITERS];
    logic [CNT_W-1:0]     rd_rank [N_READERS];
    logic [CNT_W-1:0]     wr_num;
    logic [CNT_W-1:0]     rd_num;

    assign free_entries = ENTRIES_C - count_reg;

    // Rank = number of enabled lanes below this one; a lane is granted while its
    // rank still fits in the space (or data) available at the start of the cycle.
    always_comb begin
        logic [CNT_W-1:0] seen;
        seen   = '0;
        wr_num = '0;
        for (int m = 0; m < M_WRITERS; m++) begin
            wr_rank[m]  = seen;
            wr_grant[m] = 1'b0;
            if (i_wr_en[m]) begin
                if (seen < free_entries) begin
                    wr_grant[m] = 1'b1;
                    wr_num      = wr_num + ONE_C;
                end
                seen = seen + ONE_C;
            end
        end
    end

    always_comb begin
        logic [CNT_W-1:0] seen;
        seen   = '0;
        rd_num = '0;
        for (int n = 0; n < N_READERS; n++) begin
            rd_rank[n]  = seen;
            rd_grant[n] = 1'b0;
            if (i_rd_en[n]) begin
                if (seen < count_reg) begin
                    rd_grant[n] = 1'b1;
                    rd_num      = rd_num + ONE_C;
                end
                seen = seen + ONE_C;
            end
        end
    end

    assign o_wr_ed = wr_grant;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        for (int m = 0; m < M_WRITERS; m++) begin
            if (wr_grant[m]) begin
                mem[wr_ptr_reg + wr_rank[m][DEPTH-1:0]] <= i_wr_data[m*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg + wr_num[DEPTH-1:0];
        rd_ptr_next = rd_ptr_reg + rd_num[DEPTH-1:0];
        count_next  = count_reg + wr_num - rd_num;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N_READERS; gi++) begin : g_rd_lane
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;

            // Ungranted lanes keep their last data; only valid drops.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= rd_grant[gi];
                    if (rd_grant[gi]) begin
                        data_reg <= mem[rd_ptr_reg + rd_rank[gi][DEPTH-1:0]];
                    end
                end
            end

            assign o_rd_data[gi*WIDTH +: WIDTH] = data_reg;
            assign o_rd_valid[gi]               = valid_reg;
        end
    endgenerate

    assign o_wr_full   = (count_reg == ENTRIES_C);
    assign o_wr_afull  = (free_entries < M_C);
    assign o_wr_pfull  = (free_entries <= PFULL_C);
    assign o_wr_remain = free_entries;
    assign o_rd_empty  = (count_reg == '0);
    assign o_rd_aempty = (count_reg < N_C);
    assign o_rd_pempty = (count_reg <= PEMPTY_C);
    assign o_rd_depth  = count_reg;

endmodule

// File: tb/tb_m_to_n_fifo.sv
// Directed bench for m_to_n_fifo: fill, partial grants, wrap-around drain,
// simultaneous read/write, underflow and asynchronous reset.
module tb_m_to_n_fifo;

    logic        i_clk;
    logic        i_rstn;
    logic [1:0]  i_wr_en;
    logic [15:0] i_wr_data;
    logic [1:0]  o_wr_ed;
    logic        o_wr_full;
    logic        o_wr_afull;
    logic        o_wr_pfull;
    logic [5:0]  o_wr_remain;
    logic [1:0]  i_rd_en;
    logic [15:0] o_rd_data;
    logic [1:0]  o_rd_valid;
    logic        o_rd_empty;
    logic        o_rd_aempty;
    logic        o_rd_pempty;
    logic [5:0]  o_rd_depth;

    int checks = 0;
    int errors = 0;
    int exp_depth = 0;
    logic [7:0] exp_q [$];

    m_to_n_fifo #(
        .WIDTH(8), .DEPTH(5), .PFULL_TH(8), .PEMPTY_TH(8),
        .M_WRITERS(2), .N_READERS(2)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .o_wr_ed(o_wr_ed),
        .o_wr_full(o_wr_full), .o_wr_afull(o_wr_afull), .o_wr_pfull(o_wr_pfull),
        .o_wr_remain(o_wr_remain),
        .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_rd_empty(o_rd_empty), .o_rd_aempty(o_rd_aempty), .o_rd_pempty(o_rd_pempty),
        .o_rd_depth(o_rd_depth)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One write cycle with hand-known expected grant; granted bytes go to the scoreboard.
    task automatic write_cycle(input logic [1:0] en, input logic [7:0] d1, input logic [7:0] d0,
                               input logic [1:0] exp_ed);
        i_wr_en   = en;
        i_wr_data = {d1, d0};
        #1;
        checks++;
        if (o_wr_ed !== exp_ed) begin
            errors++;
            $display("FAIL wr_ed: got %b expected %b", o_wr_ed, exp_ed);
        end
        if (exp_ed[0]) exp_q.push_back(d0);
        if (exp_ed[1]) exp_q.push_back(d1);
        exp_depth = exp_depth + int'(exp_ed[0]) + int'(exp_ed[1]);
        tick();
        i_wr_en = 2'b00;
        $display("wr en=%b data=%h_%h ed=%b depth=%0d", en, d1, d0, exp_ed, o_rd_depth);
        checks++;
        if (o_rd_depth !== 6'(exp_depth)) begin
            errors++;
            $display("FAIL wr_depth: got %0d expected %0d", o_rd_depth, exp_depth);
        end
    endtask

    // Read both lanes while at least two entries remain; checks order against the scoreboard.
    task automatic read_pair();
        logic [7:0] e0, e1;
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        exp_depth = exp_depth - 2;
        i_rd_en = 2'b11;
        tick();
        i_rd_en = 2'b00;
        $display("rd valid=%b data=%h_%h depth=%0d", o_rd_valid, o_rd_data[15:8], o_rd_data[7:0], o_rd_depth);
        checks++;
        if (o_rd_valid !== 2'b11 || o_rd_data !== {e1, e0}) begin
            errors++;
            $display("FAIL rd_pair: got valid=%b data=%h expected valid=11 data=%h", o_rd_valid, o_rd_data, {e1, e0});
        end
        checks++;
        if (o_rd_depth !== 6'(exp_depth)) begin
            errors++;
            $display("FAIL rd_depth: got %0d expected %0d", o_rd_depth, exp_depth);
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        #2;
        checks++;
        if ({o_rd_empty, o_rd_aempty, o_rd_pempty, o_wr_full, o_wr_afull, o_wr_pfull} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 111000",
                     {o_rd_empty, o_rd_aempty, o_rd_pempty, o_wr_full, o_wr_afull, o_wr_pfull});
        end
        checks++;
        if (o_wr_remain !== 6'd32 || o_rd_depth !== 6'd0 || o_rd_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_levels: got remain=%0d depth=%0d valid=%b expected 32 0 00",
                     o_wr_remain, o_rd_depth, o_rd_valid);
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
        tick();
        $display("reset released depth=%0d", o_rd_depth);
    endtask

    task automatic test_fill();
        logic [7:0] d0, d1;
        for (int i = 0; i < 16; i++) begin
            d0 = 8'(8'hA0 + 2 * i);
            d1 = 8'(8'hA1 + 2 * i);
            write_cycle(2'b11, d1, d0, 2'b11);
            checks++;
            if (o_wr_pfull !== (2 * (i + 1) >= 24)) begin
                errors++;
                $display("FAIL fill_pfull: depth=%0d got pfull=%b", o_rd_depth, o_wr_pfull);
            end
        end
        checks++;
        if (o_wr_full !== 1'b1 || o_wr_afull !== 1'b1 || o_wr_remain !== 6'd0 || o_rd_empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_flags: got full=%b afull=%b remain=%0d empty=%b expected 1 1 0 0",
                     o_wr_full, o_wr_afull, o_wr_remain, o_rd_empty);
        end
        write_cycle(2'b11, 8'h55, 8'h54, 2'b00);
    endtask

    task automatic test_read_full();
        read_pair();
        read_pair();
        checks++;
        if (o_wr_full !== 1'b0 || o_wr_remain !== 6'd4 || o_wr_afull !== 1'b0) begin
            errors++;
            $display("FAIL read_full_flags: got full=%b remain=%0d afull=%b expected 0 4 0",
                     o_wr_full, o_wr_remain, o_wr_afull);
        end
    endtask

    task automatic test_partial_write();
        write_cycle(2'b11, 8'hC1, 8'hC0, 2'b11);
        write_cycle(2'b01, 8'hEE, 8'hC2, 2'b01);
        checks++;
        if (o_wr_afull !== 1'b1 || o_wr_full !== 1'b0) begin
            errors++;
            $display("FAIL depth31_flags: got afull=%b full=%b expected 1 0", o_wr_afull, o_wr_full);
        end
        write_cycle(2'b11, 8'hC4, 8'hC3, 2'b01);
        checks++;
        if (o_wr_full !== 1'b1) begin
            errors++;
            $display("FAIL partial_full: got %b expected 1", o_wr_full);
        end
    endtask

    task automatic test_drain_wrap();
        for (int i = 0; i < 16; i++) read_pair();
        checks++;
        if (o_rd_empty !== 1'b1 || o_rd_pempty !== 1'b1 || o_rd_aempty !== 1'b1) begin
            errors++;
            $display("FAIL drain_flags: got empty=%b aempty=%b pempty=%b expected 111",
                     o_rd_empty, o_rd_aempty, o_rd_pempty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) write_cycle(2'b11, 8'(8'hD1 + 2 * i), 8'(8'hD0 + 2 * i), 2'b11);
        checks++;
        if (o_rd_pempty !== 1'b0 || o_rd_aempty !== 1'b0) begin
            errors++;
            $display("FAIL depth10_flags: got pempty=%b aempty=%b expected 0 0", o_rd_pempty, o_rd_aempty);
        end
        i_wr_en   = 2'b11;
        i_wr_data = {8'hE1, 8'hE0};
        i_rd_en   = 2'b11;
        #1;
        checks++;
        if (o_wr_ed !== 2'b11) begin
            errors++;
            $display("FAIL simul_wr_ed: got %b expected 11", o_wr_ed);
        end
        tick();
        i_wr_en = 2'b00;
        i_rd_en = 2'b00;
        $display("rd+wr valid=%b data=%h depth=%0d", o_rd_valid, o_rd_data, o_rd_depth);
        checks++;
        if (o_rd_valid !== 2'b11 || o_rd_data !== 16'hD1D0 || o_rd_depth !== 6'd10) begin
            errors++;
            $display("FAIL simul_rd: got valid=%b data=%h depth=%0d expected 11 d1d0 10",
                     o_rd_valid, o_rd_data, o_rd_depth);
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'hE1);
        for (int i = 0; i < 5; i++) read_pair();
    endtask

    task automatic test_underflow();
        write_cycle(2'b01, 8'h00, 8'hF0, 2'b01);
        exp_q.delete();
        i_rd_en = 2'b11;
        tick();
        $display("rd valid=%b data=%h depth=%0d", o_rd_valid, o_rd_data, o_rd_depth);
        checks++;
        if (o_rd_valid !== 2'b01 || o_rd_data !== 16'hE1F0 || o_rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_first: got valid=%b data=%h empty=%b expected 01 e1f0 1",
                     o_rd_valid, o_rd_data, o_rd_empty);
        end
        tick();
        i_rd_en = 2'b00;
        $display("rd valid=%b data=%h depth=%0d", o_rd_valid, o_rd_data, o_rd_depth);
        checks++;
        if (o_rd_valid !== 2'b00 || o_rd_data !== 16'hE1F0 || o_rd_depth !== 6'd0) begin
            errors++;
            $display("FAIL underflow_empty: got valid=%b data=%h depth=%0d expected 00 e1f0 0",
                     o_rd_valid, o_rd_data, o_rd_depth);
        end
        exp_depth = 0;
        write_cycle(2'b01, 8'h00, 8'hF1, 2'b01);
        i_rd_en = 2'b10;
        tick();
        i_rd_en = 2'b00;
        $display("rd valid=%b data=%h depth=%0d", o_rd_valid, o_rd_data, o_rd_depth);
        checks++;
        if (o_rd_valid !== 2'b10 || o_rd_data !== 16'hF1F0 || o_rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_ptr: got valid=%b data=%h empty=%b expected 10 f1f0 1",
                     o_rd_valid, o_rd_data, o_rd_empty);
        end
        exp_q.delete();
        exp_depth = 0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) write_cycle(2'b11, 8'(8'h31 + 2 * i), 8'(8'h30 + 2 * i), 2'b11);
        #2;
        i_rstn = 1'b0;
        #1;
        $display("async reset depth=%0d empty=%b", o_rd_depth, o_rd_empty);
        checks++;
        if (o_rd_depth !== 6'd0 || o_rd_empty !== 1'b1 || o_wr_remain !== 6'd32 || o_rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got depth=%0d empty=%b remain=%0d data=%h expected 0 1 32 0000",
                     o_rd_depth, o_rd_empty, o_wr_remain, o_rd_data);
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
        exp_q.delete();
        exp_depth = 0;
        tick();
    endtask

    initial begin
        i_rstn    = 1'b1;
        i_wr_en   = 2'b00;
        i_wr_data = 16'h0000;
        i_rd_en   = 2'b00;
        #3;
        test_reset();
        test_fill();
        test_read_full();
        test_partial_write();
        test_drain_wrap();
        test_simultaneous();
        test_underflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
